// File: rtl/rrdisp_1ton_pkg.sv
// Shared defaults for the 1-to-N round-robin dispatcher and its lane picker.
// No ports; holds the default lane count and data width used by the
// parameter lists of rrdisp_1ton and rrsel_onehot.
package rrdisp_1ton_pkg;

  localparam int unsigned DEF_REQ_CNT = 4;
  localparam int unsigned DEF_DW      = 32;

endpackage

// File: rtl/rrdisp_1ton_rrsel.sv
// rrsel_onehot: combinational round-robin lane picker.
// Returns the lowest enabled lane strictly above the one-hot pointer, or the
// lowest enabled lane overall when nothing above it is enabled (wrap).
// Ports:
//   en_mask : lane enable vector
//   ptr     : one-hot last-served lane
//   pick    : one-hot chosen lane (all zero when en_mask is zero)
module rrsel_onehot
  import rrdisp_1ton_pkg::*;
#(
  parameter int REQ_CNT = DEF_REQ_CNT
) (
  input  logic [REQ_CNT-1:0] en_mask,
  input  logic [REQ_CNT-1:0] ptr,
  output logic [REQ_CNT-1:0] pick
);

  logic [REQ_CNT-1:0] le_mask;
  logic [REQ_CNT-1:0] hi_set;
  logic [REQ_CNT-1:0] cand;

  always_comb begin
    // (ptr << 1) - 1 covers ptr's bit and everything below it; when ptr is the
    // top lane the shift overflows to zero and the mask becomes all ones.
    le_mask = (ptr << 1) - {{(REQ_CNT-1){1'b0}}, 1'b1};
    hi_set  = en_mask & ~le_mask;
    cand    = (|hi_set) ? hi_set : en_mask;
    pick    = cand & ~(cand - {{(REQ_CNT-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/rrdisp_1ton.sv
// rrdisp_1ton: splits one valid/ready stream across REQ_CNT consumer lanes in
// packet-granular round-robin order, through a one-entry registered buffer.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   en_mask          : lanes eligible for new packets
//   in_vld/in_rdy    : upstream handshake; in_data, in_last carry the beat
//   out_vld          : one-hot (or zero) lane valid
//   out_rdy          : per-lane ready, only the selected lane matters
//   out_data/out_last: buffered beat, shared by all lanes
module rrdisp_1ton
  import rrdisp_1ton_pkg::*;
#(
  parameter int REQ_CNT = DEF_REQ_CNT,
  parameter int DW      = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_CNT-1:0] en_mask,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [DW-1:0]      in_data,
  input  logic               in_last,
  output logic [REQ_CNT-1:0] out_vld,
  input  logic [REQ_CNT-1:0] out_rdy,
  output logic [DW-1:0]      out_data,
  output logic               out_last
);

  localparam logic [REQ_CNT-1:0] PTR_RST = {1'b1, {(REQ_CNT-1){1'b0}}};

  logic               buf_vld_q,   buf_vld_d;
  logic [DW-1:0]      buf_data_q,  buf_data_d;
  logic               buf_last_q,  buf_last_d;
  logic [REQ_CNT-1:0] buf_dest_q,  buf_dest_d;
  logic [REQ_CNT-1:0] ptr_q,       ptr_d;
  logic               in_pkt_q,    in_pkt_d;
  logic [REQ_CNT-1:0] lock_dest_q, lock_dest_d;

  logic [REQ_CNT-1:0] rr_pick;
  logic [REQ_CNT-1:0] dest;
  logic               out_fire;
  logic               accept;

  rrsel_onehot #(.REQ_CNT(REQ_CNT)) u_rrsel (
    .en_mask (en_mask),
    .ptr     (ptr_q),
    .pick    (rr_pick)
  );

  assign out_vld  = buf_dest_q & {REQ_CNT{buf_vld_q}};
  assign out_data = buf_data_q;
  assign out_last = buf_last_q;
  assign out_fire = |(out_vld & out_rdy);
  // A packet already in progress keeps the input open even if every lane
  // has since been disabled; it finishes on its locked lane.
  assign in_rdy   = (in_pkt_q | (|en_mask)) & (~buf_vld_q | out_fire);
  assign accept   = in_vld & in_rdy;
  assign dest     = in_pkt_q ? lock_dest_q : rr_pick;

  always_comb begin
    buf_vld_d   = buf_vld_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_dest_d  = buf_dest_q;
    ptr_d       = ptr_q;
    in_pkt_d    = in_pkt_q;
    lock_dest_d = lock_dest_q;
    if (accept) begin
      buf_vld_d  = 1'b1;
      buf_data_d = in_data;
      buf_last_d = in_last;
      buf_dest_d = dest;
      if (in_last) begin
        // Pointer moves only at packet end, so arbitration is per packet.
        ptr_d    = dest;
        in_pkt_d = 1'b0;
      end else begin
        in_pkt_d    = 1'b1;
        lock_dest_d = dest;
      end
    end else if (out_fire) begin
      buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q   <= 1'b0;
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_dest_q  <= '0;
      ptr_q       <= PTR_RST;
      in_pkt_q    <= 1'b0;
      lock_dest_q <= '0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_dest_q  <= buf_dest_d;
      ptr_q       <= ptr_d;
      in_pkt_q    <= in_pkt_d;
      lock_dest_q <= lock_dest_d;
    end
  end

endmodule

// File: tb/tb_rrdisp_1ton.sv
module tb_rrdisp_1ton;

  localparam int R  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [R-1:0]  en_mask;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [R-1:0]  out_vld;
  logic [R-1:0]  out_rdy;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  rrdisp_1ton #(.REQ_CNT(R), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_mask  (en_mask),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_last (out_last)
  );

  typedef struct {
    int            lane;
    logic [DW-1:0] data;
    logic          last;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: last-served lane index, packet-in-progress flag and the
  // lane the current packet is locked to.
  int m_last_lane;
  bit m_mid;
  int m_lock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_lane(input logic [R-1:0] e, input int last);
    for (int k = 1; k <= R; k++) begin
      int c;
      c = (last + k) % R;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: whenever the scoreboard holds a beat the DUT must be showing it.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("idle_out_vld", {28'd0, out_vld}, 32'd0);
      end else begin
        chk("out_vld",  {28'd0, out_vld}, 32'd1 << sb[0].lane);
        chk("out_data", {24'd0, out_data}, {24'd0, sb[0].data});
        chk("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
        if (out_rdy[sb[0].lane]) void'(sb.pop_front());
      end
    end
  end

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic [R-1:0] e, input logic [R-1:0] r, output bit acc);
    bit exp_rdy;
    int lane;
    item_t it;
    @(posedge clk); #1;
    rst = 1'b0; in_vld = v; in_data = d; in_last = l; en_mask = e; out_rdy = r;
    @(negedge clk); #2;
    exp_rdy = (m_mid || (e != '0)) && (sb.size() == 0);
    chk("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    if (acc) begin
      lane = m_mid ? m_lock : next_lane(e, m_last_lane);
      it.lane = lane; it.data = d; it.last = l;
      sb.push_back(it);
      if (l) begin
        m_last_lane = lane;
        m_mid = 1'b0;
      end else begin
        m_mid = 1'b1;
        m_lock = lane;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_vld = 1'b0; en_mask = '0; out_rdy = '0;
    @(negedge clk); #2;
    sb.delete();
    m_last_lane = R - 1;
    m_mid = 1'b0;
    m_lock = 0;
  endtask

  task automatic drain();
    bit acc;
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      cycle(1'b0, '0, 1'b1, 4'b1111, 4'b1111, acc);
      budget++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_last = 1'b0; en_mask = '0; out_rdy = '0;
    m_last_lane = R - 1; m_mid = 1'b0; m_lock = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state: nothing valid, input closed with no lanes enabled.
    cycle(1'b0, '0, 1'b1, 4'b0000, 4'b1111, acc);
    chk("rst_out_vld", {28'd0, out_vld}, 32'd0);
    chk("rst_in_rdy",  {31'd0, in_rdy}, 32'd0);

    // 1: back-to-back singles across all lanes.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b1, 4'b1111, 4'b1111, acc);
      chk("t1_accept", {31'd0, acc}, 32'd1);
    end
    drain();

    // 2: alternate lanes 1,3.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b1, 4'b1010, 4'b1111, acc);
    drain();

    // 3: three-beat packet stays locked on lane 0 despite en change.
    do_reset();
    cycle(1'b1, 8'hA0, 1'b0, 4'b1111, 4'b1111, acc);
    cycle(1'b1, 8'hA1, 1'b0, 4'b0001, 4'b1111, acc);
    cycle(1'b1, 8'hA2, 1'b1, 4'b0001, 4'b1111, acc);
    cycle(1'b1, 8'hB0, 1'b1, 4'b1111, 4'b1111, acc);
    drain();

    // 4: stalled lane 0 holds the beat; fire and accept in the same cycle.
    do_reset();
    cycle(1'b1, 8'h55, 1'b1, 4'b1111, 4'b1110, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h56, 1'b1, 4'b1111, 4'b1110, acc);
      chk("t4_stall_noacc", {31'd0, acc}, 32'd0);
    end
    cycle(1'b1, 8'h56, 1'b1, 4'b1111, 4'b1111, acc);
    chk("t4_fire_accept", {31'd0, acc}, 32'd1);
    drain();

    // 5: no lanes enabled blocks input; then lane 2 only.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h77, 1'b1, 4'b0000, 4'b1111, acc);
    cycle(1'b1, 8'h77, 1'b1, 4'b0100, 4'b1111, acc);
    chk("t5_accept", {31'd0, acc}, 32'd1);
    drain();

    // 6: reset while a packet's first beat sits buffered for lane 1.
    do_reset();
    cycle(1'b1, 8'h60, 1'b1, 4'b1111, 4'b1111, acc);
    cycle(1'b1, 8'h61, 1'b0, 4'b1111, 4'b0000, acc);
    cycle(1'b0, 8'h00, 1'b0, 4'b1111, 4'b0000, acc);
    do_reset();
    cycle(1'b0, 8'h00, 1'b1, 4'b1111, 4'b1111, acc);
    chk("t6_post_rst_vld", {28'd0, out_vld}, 32'd0);
    cycle(1'b1, 8'h62, 1'b1, 4'b1111, 4'b1111, acc);
    drain();

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
    end
    // Close any open packet so the buffer can drain.
    for (int i = 0; i < 20 && m_mid; i++) cycle(1'b1, 8'hEE, 1'b1, 4'b1111, 4'b1111, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
